gray_count_monitor: RTL and testbench

Downstream consumer of the 8-bit Gray code counter. Samples the Gray count through a synchroniser chain, converts it to binary and classifies every sampled transition as hold, single step, wrap or error. A small state machine tracks warm-up, healthy tracking and latched fault, and a saturating error counter gives the monitor and test logic a running health figure.

---
 rtl/gray_count_monitor.sv | 180 ++++++++++++++++++
 tb/tb_gray_count_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_count_monitor.sv
// gray_count_monitor
//   Consumes the Gray count of an upstream counter. The count passes through
//   a synchroniser chain and is converted to binary. Each sampled transition
//   is classified as hold, single step, wrap or error. A three-state FSM
//   tracks warm-up, healthy tracking and latched fault. A saturating counter
//   holds the number of errors seen since reset or the last clear.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   gray_in    in   [WIDTH-1:0] Gray count from the upstream counter
//   err_clr    in   clears the fault state and err_cnt
//   bin_out    out  [WIDTH-1:0] registered binary value of the synchronised input
//   bin_valid  out  bin_out holds a real sample (low during warm-up)
//   step       out  one-cycle pulse: value advanced by exactly +1 (mod 2^WIDTH)
//   wrap       out  one-cycle pulse: all-ones to zero (step is high as well)
//   err        out  one-cycle pulse: any change other than hold or +1
//   fault      out  high while the FSM is in FAULT
//   err_cnt    out  [7:0] errors since reset/clear, saturating at 255
//   state_dbg  out  [1:0] FSM state: 0 = WARMUP, 1 = TRACK, 2 = FAULT
//
// Handshake: none. Every cycle is a sample; there is no valid/ready flow
// control and no backpressure, so one classification is made per edge.
module gray_count_monitor #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step,
  output logic             wrap,
  output logic             err,
  output logic             fault,
  output logic [7:0]       err_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [2:0]       warm_cnt_q, warm_cnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             valid_q, valid_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] bin_plus1;
  logic             acc;
  logic             is_err;

  // Synchroniser shift chain.
  always_comb begin
    sync_d[0] = gray_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign g = sync_q[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above
  // it, accumulated from the MSB downwards.
  always_comb begin
    b   = '0;
    acc = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
  end

  assign bin_plus1 = bin_q + WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    bin_d      = bin_q;
    valid_d    = valid_q;
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    is_err     = 1'b0;

    case (state_q)
      WARMUP: begin
        // Wait until the first real sample has reached the chain output; the
        // load edge itself is not classified.
        if (warm_cnt_q == 3'(SYNC_STAGES)) begin
          bin_d   = b;
          valid_d = 1'b1;
          state_d = TRACK;
        end else begin
          warm_cnt_d = warm_cnt_q + 3'd1;
        end
      end

      TRACK, FAULT: begin
        bin_d = b;
        if (b == bin_q) begin
          is_err = 1'b0;
        end else if (b == bin_plus1) begin
          step_d = 1'b1;
          wrap_d = &bin_q;
        end else begin
          is_err = 1'b1;
        end
        err_d = is_err;

        // An error arriving together with a clear wins: the clear empties
        // the count and this error is then its first entry.
        if (is_err) begin
          state_d = FAULT;
          if (err_clr) begin
            err_cnt_d = 8'd1;
          end else if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else if (err_clr) begin
          err_cnt_d = 8'd0;
          state_d   = TRACK;
        end
      end

      default: state_d = WARMUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WARMUP;
      warm_cnt_q <= 3'd0;
      bin_q      <= '0;
      valid_q    <= 1'b0;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      bin_q      <= bin_d;
      valid_q    <= valid_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign bin_out   = bin_q;
  assign bin_valid = valid_q;
  assign step      = step_q;
  assign wrap      = wrap_q;
  assign err       = err_q;
  assign fault     = (state_q == FAULT);
  assign err_cnt   = err_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_gray_count_monitor.sv
module tb_gray_count_monitor;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] gray_in = 8'h00;
  logic       err_clr = 1'b0;
  logic [7:0] bin_out;
  logic       bin_valid, step, wrap, err, fault;
  logic [7:0] err_cnt;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  gray_count_monitor #(.WIDTH(8), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .err_clr(err_clr),
    .bin_out(bin_out), .bin_valid(bin_valid), .step(step), .wrap(wrap),
    .err(err), .fault(fault), .err_cnt(err_cnt), .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  logic [7:0] samp_q[$];
  logic [7:0] m_bin;
  bit         m_valid, m_step, m_wrap, m_err, m_fault;
  int         m_cnt;

  function automatic logic [7:0] to_gray(int v);
    logic [7:0] x;
    x = 8'(v);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [7:0] from_gray(logic [7:0] gv);
    logic [7:0] r;
    r = 8'h00;
    for (int s = 0; s < 8; s++) r = r ^ (gv >> s);
    return r;
  endfunction

  function automatic void model_edge(bit r, logic [7:0] gv, bit clr);
    logic [7:0] nb;
    m_step = 0; m_wrap = 0; m_err = 0;
    if (r) begin
      samp_q.delete();
      m_bin = 8'h00; m_valid = 0; m_fault = 0; m_cnt = 0;
      return;
    end
    samp_q.push_back(gv);
    if (samp_q.size() <= S) return;
    nb = from_gray(samp_q.pop_front());
    if (!m_valid) begin
      m_valid = 1;
    end else if (nb == m_bin) begin
      // hold
    end else if (int'(nb) == (int'(m_bin) + 1) % 256) begin
      m_step = 1;
      m_wrap = (m_bin == 8'd255);
    end else begin
      m_err   = 1;
      m_fault = 1;
      m_cnt   = clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
    end
    if (!m_err && clr) begin
      m_cnt   = 0;
      m_fault = 0;
    end
    m_bin = nb;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  int step_seen, wrap_seen, err_seen;

  // One clock edge: model follows the same sampled inputs, outputs compared
  // 1 time unit after the edge.
  task automatic step_cycle();
    @(posedge clk);
    model_edge(rst, gray_in, err_clr);
    #1;
    check("bin_out",   32'(bin_out),   32'(m_bin));
    check("bin_valid", 32'(bin_valid), 32'(m_valid));
    check("step",      32'(step),      32'(m_step));
    check("wrap",      32'(wrap),      32'(m_wrap));
    check("err",       32'(err),       32'(m_err));
    check("fault",     32'(fault),     32'(m_fault));
    check("err_cnt",   32'(err_cnt),   32'(m_cnt));
    check("state_dbg", 32'(state_dbg), !m_valid ? 32'd0 : (m_fault ? 32'd2 : 32'd1));
    step_seen += int'(step);
    wrap_seen += int'(wrap);
    err_seen  += int'(err);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [7:0] gv, input logic clr, input logic r);
    gray_in = gv;
    err_clr = clr;
    rst     = r;
    step_cycle();
  endtask

  typedef struct {
    logic [7:0] gray;
    logic       clr;
    logic       valid;
    logic [7:0] bin;
    logic       stp;
    logic       er;
    logic       flt;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int cur;

    // Hold/skip, fault clear and collision table. Outputs lag gray_in by two
    // edges; err_clr acts on the edge it is applied.
    for (int i = 0; i < 8; i++) tbl[i] = '{8'h0C, 1'b0, 1'b1, 8'd8, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[0]  = '{8'h0C, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{8'h0C, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0};
    tbl[8]  = '{8'h0F, 1'b0, 1'b1, 8'd8,  1'b0, 1'b0, 1'b0, 8'd0};
    tbl[9]  = '{8'h0E, 1'b0, 1'b1, 8'd8,  1'b0, 1'b0, 1'b0, 8'd0};
    tbl[10] = '{8'h1E, 1'b0, 1'b1, 8'd10, 1'b0, 1'b1, 1'b1, 8'd1};
    tbl[11] = '{8'h1F, 1'b1, 1'b1, 8'd11, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[12] = '{8'h02, 1'b0, 1'b1, 8'd20, 1'b0, 1'b1, 1'b1, 8'd1};
    tbl[13] = '{8'h06, 1'b0, 1'b1, 8'd21, 1'b1, 1'b0, 1'b1, 8'd1};
    tbl[14] = '{8'h06, 1'b1, 1'b1, 8'd3,  1'b0, 1'b1, 1'b1, 8'd1};
    tbl[15] = '{8'h06, 1'b0, 1'b1, 8'd4,  1'b1, 1'b0, 1'b1, 8'd1};
    tbl[16] = '{8'h06, 1'b0, 1'b1, 8'd4,  1'b0, 1'b0, 1'b1, 8'd1};

    // ---- reset and warm-up ----
    drive(8'h00, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b1);
    check("reset_outputs", {bin_out, bin_valid, step, wrap, err, fault, err_cnt}, 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    drive(8'h00, 1'b0, 1'b0);
    check("warm_edge1_valid", 32'(bin_valid), 32'd0);
    drive(8'h00, 1'b0, 1'b0);
    check("warm_edge2_valid", 32'(bin_valid), 32'd0);
    drive(8'h00, 1'b0, 1'b0);
    check("warm_edge3_valid", 32'(bin_valid), 32'd1);
    check("warm_edge3_bin", 32'(bin_out), 32'd0);
    check("warm_edge3_pulses", {step, wrap, err}, 32'd0);

    // ---- full count ----
    step_seen = 0; wrap_seen = 0; err_seen = 0;
    for (int c = 1; c <= 260; c++) drive(to_gray(c), 1'b0, 1'b0);
    check("count_steps", step_seen, 32'd258);
    check("count_wraps", wrap_seen, 32'd1);
    check("count_errs", err_seen, 32'd0);
    check("count_err_cnt", 32'(err_cnt), 32'd0);
    check("count_bin_lag", 32'(bin_out), 32'd2);

    // ---- hold/skip, clear, collision (table) ----
    drive(8'h0C, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].gray, tbl[i].clr, 1'b0);
      check($sformatf("tbl%0d_valid", i), 32'(bin_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_bin", i),   32'(bin_out),   32'(tbl[i].bin));
      check($sformatf("tbl%0d_step", i),  32'(step),      32'(tbl[i].stp));
      check($sformatf("tbl%0d_err", i),   32'(err),       32'(tbl[i].er));
      check($sformatf("tbl%0d_fault", i), 32'(fault),     32'(tbl[i].flt));
      check($sformatf("tbl%0d_cnt", i),   32'(err_cnt),   32'(tbl[i].cnt));
    end

    // ---- saturation ----
    err_seen = 0;
    for (int i = 0; i < 300; i++) drive(to_gray((i % 2) ? 5 : 0), 1'b0, 1'b0);
    check("sat_err_cnt", 32'(err_cnt), 32'd255);
    check("sat_err_pulses", err_seen, 32'd298);
    check("sat_err_last", 32'(err), 32'd1);

    // ---- randomized run against the model ----
    cur = 0;
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 70)      cur = (cur + 1) % 256;
      else if (r > 85) cur = int'($urandom_range(0, 255));
      drive(to_gray(cur), ($urandom_range(0, 19) == 0), ($urandom_range(0, 199) == 0));
    end

    // ---- mid-run reset while counting at 0x40 ----
    drive(8'h00, 1'b0, 1'b1);
    for (int c = 0; c <= 8'h40; c++) drive(to_gray(c), 1'b0, 1'b0);
    drive(to_gray(8'h41), 1'b0, 1'b1);
    check("mid_reset_outputs", {bin_out, bin_valid, step, wrap, err, fault, err_cnt}, 32'd0);
    check("mid_reset_state", 32'(state_dbg), 32'd0);
    drive(to_gray(8'h42), 1'b0, 1'b0);
    check("mid_warm1_valid", 32'(bin_valid), 32'd0);
    drive(to_gray(8'h43), 1'b0, 1'b0);
    check("mid_warm2_valid", 32'(bin_valid), 32'd0);
    drive(to_gray(8'h44), 1'b0, 1'b0);
    check("mid_warm3_valid", 32'(bin_valid), 32'd1);
    check("mid_warm3_bin", 32'(bin_out), 32'h42);
    check("mid_warm3_pulses", {step, wrap, err}, 32'd0);
    drive(to_gray(8'h45), 1'b0, 1'b0);
    check("mid_first_step", 32'(step), 32'd1);

    // ---- final report ----
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
